// File: rtl/delta_pkg.sv
// Shared types and constants for the send-on-delta decoder.
package delta_pkg;

   // Parser FSM states
   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_VAL = 1'b1
   } state_t;

   // Default protocol constants
   localparam int          DEF_DEADBAND = 2;
   localparam int          DEF_TIMEOUT  = 16;
   localparam logic [3:0]  DEF_SYNC     = 4'hA;

   // Header field positions
   localparam int HDR_SYNC_MSB = 7;
   localparam int HDR_SYNC_LSB = 4;
   localparam int HDR_RSVD_MSB = 3;
   localparam int HDR_RSVD_LSB = 2;
   localparam int HDR_CH_MSB   = 1;
   localparam int HDR_CH_LSB   = 0;

   // A header is valid when the sync nibble matches and reserved bits are zero
   function automatic logic hdr_valid(input logic [7:0] b, input logic [3:0] sync);
      return (b[HDR_SYNC_MSB:HDR_SYNC_LSB] == sync) &&
             (b[HDR_RSVD_MSB:HDR_RSVD_LSB] == 2'b00);
   endfunction

endpackage

// File: rtl/delta_frame_parser.sv
// Frame parser: header check, channel latch, inter-byte timeout.
// Handshake: a byte is consumed on every rising clk where strobe=1; there is
// no ready/backpressure. wr_req is a combinational one-cycle request that is
// valid in the cycle the value byte is presented; the consumer commits it on
// the same edge that consumes the byte.
module delta_frame_parser
   import delta_pkg::*;
#(
   parameter int         TIMEOUT = DEF_TIMEOUT,
   parameter logic [3:0] SYNC    = DEF_SYNC
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       strobe,
   input  logic [7:0] data,
   output logic       wr_req,
   output logic [1:0] wr_ch,
   output logic [7:0] wr_val,
   output logic       frame_err_set,
   output logic       busy,
   output state_t     dbg_state
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] timer, timer_nxt;
   logic [1:0] ch, ch_nxt;

   // State, timer and channel registers; reset input is active-high
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state <= IDLE;
         timer <= 8'd0;
         ch    <= 2'd0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         ch    <= ch_nxt;
      end
   end

   // Next-state logic; a strobe in WAIT_VAL wins over the timeout
   always_comb begin
      state_nxt     = state;
      timer_nxt     = timer;
      ch_nxt        = ch;
      wr_req        = 1'b0;
      frame_err_set = 1'b0;
      case (state)
         IDLE: begin
            if (strobe) begin
               if (hdr_valid(data, SYNC)) begin
                  ch_nxt    = data[HDR_CH_MSB:HDR_CH_LSB];
                  timer_nxt = 8'd0;
                  state_nxt = WAIT_VAL;
               end else begin
                  frame_err_set = 1'b1;
               end
            end
         end
         WAIT_VAL: begin
            if (strobe) begin
               wr_req    = 1'b1;
               state_nxt = IDLE;
            end else if (timer == TMO_LAST) begin
               frame_err_set = 1'b1;
               state_nxt     = IDLE;
            end else begin
               timer_nxt = timer + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign wr_ch     = ch;
   assign wr_val    = data;
   assign busy      = (state == WAIT_VAL);
   assign dbg_state = state;

endmodule

// File: rtl/tt_um_delta_dec.sv
// Send-on-delta decoder top: shadow registers, deadband check, sticky errors,
// readout mux.
module tt_um_delta_dec
   import delta_pkg::*;
#(
   parameter int         DEADBAND = DEF_DEADBAND,
   parameter int         TIMEOUT  = DEF_TIMEOUT,
   parameter logic [3:0] SYNC     = DEF_SYNC
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [7:0] DB = 8'(DEADBAND);

   logic       wr_req, frame_err_set, busy;
   logic [1:0] wr_ch;
   logic [7:0] wr_val;
   state_t     dbg_state;

   logic [7:0] shadow [4];
   logic [7:0] cur, diff;
   logic       delta_ok, dband_err_set;
   logic       upd, frame_err, dband_err;
   logic [1:0] last_ch;

   delta_frame_parser #(
      .TIMEOUT (TIMEOUT),
      .SYNC    (SYNC)
   ) u_parser (
      .clk           (clk),
      .rst_n         (rst_n),
      .strobe        (uio_in[0]),
      .data          (ui_in),
      .wr_req        (wr_req),
      .wr_ch         (wr_ch),
      .wr_val        (wr_val),
      .frame_err_set (frame_err_set),
      .busy          (busy),
      .dbg_state     (dbg_state)
   );

   // Absolute difference against the addressed shadow, larger minus smaller
   always_comb begin
      cur           = shadow[wr_ch];
      diff          = (wr_val >= cur) ? (wr_val - cur) : (cur - wr_val);
      delta_ok      = (diff > DB);
      dband_err_set = wr_req && !delta_ok;
   end

   // Shadow update, update pulse and last-updated channel
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) shadow[i] <= 8'd0;
         upd     <= 1'b0;
         last_ch <= 2'd0;
      end else begin
         upd <= wr_req && delta_ok;
         if (wr_req && delta_ok) begin
            shadow[wr_ch] <= wr_val;
            last_ch       <= wr_ch;
         end
      end
   end

   // Sticky errors: a set event in the same cycle as clear keeps the flag set
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         frame_err <= 1'b0;
         dband_err <= 1'b0;
      end else begin
         if (frame_err_set)  frame_err <= 1'b1;
         else if (uio_in[3]) frame_err <= 1'b0;
         if (dband_err_set)  dband_err <= 1'b1;
         else if (uio_in[3]) dband_err <= 1'b0;
      end
   end

   assign uo_out  = shadow[uio_in[2:1]];
   assign uio_out = {busy, dband_err, frame_err, upd, 4'b0000};
   assign uio_oe  = 8'hF0;

   // Inputs without function, plus debug-only state kept visible in one place
   wire unused_ok = &{1'b0, ena, uio_in[7:4], last_ch, dbg_state};

endmodule

// File: tb/tb_tt_um_delta_dec.sv
// Directed testbench for tt_um_delta_dec (DEADBAND=2, TIMEOUT=16, SYNC=A).
module tb_tt_um_delta_dec;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic       stb = 1'b0;
   logic [1:0] sel = 2'd0;
   logic       clr = 1'b0;
   logic [7:0] uio_in;
   logic [7:0] uo_out, uio_out, uio_oe;

   int checks = 0;
   int failures = 0;
   int upd_cnt;

   assign uio_in = {4'b0000, clr, sel, stb};

   tt_um_delta_dec dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // Clock
   always #5 clk = ~clk;

   // Compare and count
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present inputs (called at a negedge), let one rising edge pass, return at next negedge
   task automatic step(input logic s, input logic [7:0] b);
      stb   = s;
      ui_in = b;
      @(negedge clk);
      stb = 1'b0;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_uio", uio_out, 8'h00);
      chk("rst_oe", uio_oe, 8'hF0);
      rst_n = 1'b0;
      @(negedge clk);

      // Basic frame A1,50; same-cycle read of the channel being written shows old value
      step(1'b1, 8'hA1);
      chk("busy_after_hdr", uio_out, 8'h80);
      sel   = 2'd1;
      stb   = 1'b1;
      ui_in = 8'h50;
      #1 chk("old_value_during_write", uo_out, 8'h00);
      @(negedge clk);
      stb = 1'b0;
      chk("upd_pulse", uio_out, 8'h10);
      chk("shadow1_50", uo_out, 8'h50);
      step(1'b0, 8'h00);
      chk("upd_one_cycle", uio_out, 8'h00);

      // Deadband: diff 2 rejected, diff 3 accepted
      step(1'b1, 8'hA1);
      step(1'b1, 8'h52);
      chk("dband_err", uio_out, 8'h40);
      chk("shadow1_kept", uo_out, 8'h50);
      step(1'b1, 8'hA1);
      step(1'b1, 8'h53);
      chk("dband_ok_upd", uio_out, 8'h50);
      chk("shadow1_53", uo_out, 8'h53);
      clr = 1'b1;
      step(1'b0, 8'h00);
      clr = 1'b0;
      chk("clr_dband", uio_out, 8'h00);

      // Equal value is a violation
      step(1'b1, 8'hA1);
      step(1'b1, 8'h53);
      chk("equal_dband", uio_out, 8'h40);
      clr = 1'b1;
      step(1'b0, 8'h00);
      clr = 1'b0;

      // Bad headers, then a good frame
      step(1'b1, 8'hB0);
      chk("bad_sync", uio_out, 8'h20);
      step(1'b1, 8'hA4);
      chk("bad_rsvd", uio_out, 8'h20);
      step(1'b1, 8'hA2);
      chk("good_hdr_after_err", uio_out, 8'hA0);
      step(1'b1, 8'h10);
      sel = 2'd2;
      chk("ch2_upd", uio_out, 8'h30);
      #1 chk("shadow2_10", uo_out, 8'h10);
      clr = 1'b1;
      step(1'b0, 8'h00);
      chk("clr_frame", uio_out, 8'h00);
      // Set beats clear
      step(1'b1, 8'hC3);
      clr = 1'b0;
      chk("set_wins", uio_out, 8'h20);
      clr = 1'b1;
      step(1'b0, 8'h00);
      clr = 1'b0;

      // Timeout: header then 16 idle edges
      step(1'b1, 8'hA3);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h00);
      chk("busy_before_tmo", uio_out, 8'h80);
      step(1'b0, 8'h00);
      chk("timeout", uio_out, 8'h20);
      clr = 1'b1;
      step(1'b0, 8'h00);
      clr = 1'b0;
      // Strobe on the 16th edge is accepted as the value
      step(1'b1, 8'hA3);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h00);
      step(1'b1, 8'h77);
      sel = 2'd3;
      chk("strobe_beats_tmo", uio_out, 8'h10);
      #1 chk("shadow3_77", uo_out, 8'h77);

      // Back-to-back frames on consecutive edges
      upd_cnt = 0;
      step(1'b1, 8'hA0); upd_cnt += int'(uio_out[4]);
      step(1'b1, 8'h10); upd_cnt += int'(uio_out[4]);
      step(1'b1, 8'hA1); upd_cnt += int'(uio_out[4]);
      step(1'b1, 8'h20); upd_cnt += int'(uio_out[4]);
      step(1'b1, 8'hA2); upd_cnt += int'(uio_out[4]);
      step(1'b1, 8'h30); upd_cnt += int'(uio_out[4]);
      step(1'b1, 8'hA3); upd_cnt += int'(uio_out[4]);
      step(1'b1, 8'h40); upd_cnt += int'(uio_out[4]);
      chk("b2b_upd_count", 8'(upd_cnt), 8'd4);
      chk("b2b_no_err", uio_out, 8'h10);
      sel = 2'd0; #1 chk("b2b_sh0", uo_out, 8'h10);
      sel = 2'd1; #1 chk("b2b_sh1", uo_out, 8'h20);
      sel = 2'd2; #1 chk("b2b_sh2", uo_out, 8'h30);
      sel = 2'd3; #1 chk("b2b_sh3", uo_out, 8'h40);
      @(negedge clk);

      // Async reset mid-frame
      step(1'b1, 8'hA1);
      chk("mid_busy", uio_out, 8'h80);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_uio", uio_out, 8'h00);
      chk("mid_rst_sh3", uo_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      step(1'b1, 8'h50);
      chk("value_as_header", uio_out, 8'h20);
      sel = 2'd1; #1 chk("mid_rst_sh1", uo_out, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tt_um_delta_dec.md
# tt_um_delta_dec

Send-on-delta decoder: the receiving end of the 4-channel deadband change-detector link. Accepts two-byte update frames (header + value) on the dedicated inputs, checks framing and deadband legality, and maintains four shadow registers that reconstruct the last reported value of each channel. Any shadow register can be read combinationally on `uo_out`; status and update events are driven on the upper bidirectional pins.

## Interface
Parameters:
- `DEADBAND`, 2: minimum legal |new − shadow| is `DEADBAND+1`; smaller deltas are protocol violations.
- `TIMEOUT`, 16: maximum idle cycles between header and value byte; range 1–255.
- `SYNC`, 4'hA: required header upper nibble.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-high (despite the name)
- `ena`  in  1  ignored
- `ui_in`  in  8  frame byte
- `uio_in`  in  8  [0] byte strobe; [2:1] read select; [3] error clear; [7:4] unused
- `uo_out`  out  8  shadow[read select]
- `uio_out`  out  8  [3:0] = 0; [4] upd pulse; [5] frame_err sticky; [6] dband_err sticky; [7] busy (waiting for value byte)
- `uio_oe`  out  8  constant 8'hF0

## Operation
- Byte accepted on every rising `clk` with `uio_in[0]`=1; no backpressure.
- Header: `[7:4]`=`SYNC`, `[3:2]`=2'b00, `[1:0]`=channel. Value byte: raw 8-bit sample.
- FSM states:
  - IDLE: accepted byte with valid header → latch channel, clear timer, go WAIT_VAL. Invalid header → set frame_err, stay IDLE.
  - WAIT_VAL: accepted byte is the value (no header check). Compute |value − shadow[ch]| unsigned 8-bit, no wrap: larger minus smaller. If > `DEADBAND` → write shadow[ch], pulse upd, record channel. Else → set dband_err, shadow unchanged. Either way → IDLE. No strobe: timer increments; when timer reaches `TIMEOUT` → set frame_err, → IDLE, frame discarded.
- Equal value (diff 0) is a deadband violation.
- `uio_in[3]`=1 clears both sticky errors; if an error-setting event occurs in the same cycle, set wins.
- `uo_out` is a combinational mux of shadows on `uio_in[2:1]`; no handshake for readout.

## Timing
- Reset (async assert): shadows 0, FSM IDLE, timer 0, upd 0, frame_err 0, dband_err 0, busy 0. `uo_out`=0.
- Value byte accepted at edge N → shadow and `uo_out` updated after edge N; upd high for exactly the cycle following edge N.
- Back-to-back frames legal: header may be accepted on the edge immediately after a value byte.
- busy = (state == WAIT_VAL), registered.
- Timeout: header at edge N, no strobe → frame_err set at edge N+`TIMEOUT`; a strobe at that same edge is accepted as the value (strobe beats timeout).
- Reset mid-frame: partial frame discarded, no upd, no error.
- Read select and write to the same channel in one cycle: `uo_out` shows the old value until after the edge.

## Structure
- Package `delta_pkg`: state enum (IDLE, WAIT_VAL), default `SYNC`, `DEADBAND`, `TIMEOUT` constants, header field positions.
- Sub-module `delta_frame_parser`: FSM, timer, header check; outputs a one-cycle write request (channel, value). Top holds shadows, deadband compare, sticky errors, readout mux.

## Test plan
- Reset, frame 0xA1,0x50 → shadow[1]=0x50, upd one cycle, select 1 → `uo_out`=0x50, no errors.
- Shadow[1]=0x50; frame 0xA1,0x52 → dband_err=1, shadow unchanged; frame 0xA1,0x53 → shadow=0x53.
- Bad header 0xB0 and 0xA4 → frame_err set, FSM stays IDLE; following 0xA2,0x10 decodes correctly; clear pin drops frame_err.
- Header 0xA3, 16 idle cycles → frame_err, busy falls; with strobe on cycle 16 → value accepted instead.
- Four back-to-back frames (ch0..3 = 0x10,0x20,0x30,0x40) on consecutive cycles → all shadows correct, four upd pulses.
- Async reset asserted between header and value → shadows 0, busy 0, next value-looking byte treated as header (frame_err if invalid).
